// File: rtl/sram_mem_responder_pkg.sv
// Shared constants for the Mem-stage SRAM responder: bus widths, address
// mapping defaults and the access-sequencer state encoding.
package sram_mem_responder_pkg;

  // Pipeline word and byte-address widths
  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned ADDRESS_LEN = 32;

  // External SRAM geometry and mapping defaults
  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam int unsigned SRAM_DATA_W_DEF = 16;
  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  // Access sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Byte offset of a pipeline address from the SRAM window base (wraps silently)
  function automatic logic [ADDRESS_LEN-1:0] addr_offset(
    input logic [ADDRESS_LEN-1:0] addr,
    input logic [ADDRESS_LEN-1:0] base
  );
    return addr - base;
  endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// Single-entry last-word read buffer: one tag/data/valid entry with a
// combinational hit compare, a fill port for read misses and a
// write-through port that refreshes the data when the tagged word is written.
module sram_read_buffer
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned TAG_W  = 17,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_c_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              fill_i,
  input  logic              wr_i,
  input  logic [TAG_W-1:0]  upd_tag_i,
  input  logic [DATA_W-1:0] upd_data_i
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next entry contents: fill replaces the entry, write-through only on tag match
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = upd_tag_i;
      data_d  = upd_data_i;
    end else if (wr_i && valid_q && (tag_q == upd_tag_i)) begin
      data_d  = upd_data_i;
    end
  end

  // Entry registers; reset invalidates
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_c_o = valid_q && (tag_q == lookup_tag_i);
  assign data_o  = data_q;

endmodule

// File: rtl/sram_mem_responder.sv
// Mem-stage data-memory responder for a 16-bit asynchronous SRAM. Each 32-bit
// word is moved as two half-word accesses (low half, then high half), each
// held for WAIT_CYCLES cycles; ready is low while busy to freeze the pipeline.
// Optional: define SRAM_RD_BUF_EN to add a single-entry last-word read buffer.
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int unsigned SRAM_DATA_W = SRAM_DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [ADDRESS_LEN-1:0] ALU_Res,
  input  logic [WORD_LEN-1:0]    Val_RM,
  output logic [WORD_LEN-1:0]    memory_out,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic                   SRAM_WE_N
);

  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [1:0]             state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   wr_q,      wr_d;
  logic [WORD_W-1:0]      word_q,    word_d;
  logic [SRAM_DATA_W-1:0] lo_q,      lo_d;
  logic [WORD_LEN-1:0]    mem_out_q, mem_out_d;
  logic [SRAM_ADDR_W-1:0] addr_q,    addr_d;
  logic                   we_n_q,    we_n_d;
  logic [SRAM_DATA_W-1:0] dout_q,    dout_d;
  logic                   oe_q,      oe_d;
  logic                   ready_c;

  logic                   req_c;
  logic                   last_c;
  logic [ADDRESS_LEN-1:0] offset_c;
  logic [WORD_W-1:0]      req_word_c;
  logic                   unused_offset_bits;

  // Word index of the incoming request; byte-lane bits and upper bits dropped
  assign req_c              = MEM_R_EN | MEM_W_EN;
  assign offset_c           = addr_offset(ALU_Res, ADDRESS_LEN'(BASE_ADDR));
  assign req_word_c         = offset_c[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset_c[1:0], offset_c[ADDRESS_LEN-1:SRAM_ADDR_W+1]};
  assign last_c             = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

`ifdef SRAM_RD_BUF_EN
  logic                buf_hit_c;
  logic [WORD_LEN-1:0] buf_data;
  logic                buf_fill_c;
  logic                buf_wr_c;
  logic [WORD_LEN-1:0] buf_upd_data_c;

  // Read misses refill at DONE; writes go through to a matching entry
  assign buf_fill_c     = (state_q == ST_DONE) && !wr_q;
  assign buf_wr_c       = (state_q == ST_DONE) &&  wr_q;
  assign buf_upd_data_c = wr_q ? Val_RM : mem_out_q;

  sram_read_buffer #(
    .TAG_W  (WORD_W),
    .DATA_W (WORD_LEN)
  ) u_rd_buf (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (req_word_c),
    .hit_c_o      (buf_hit_c),
    .data_o       (buf_data),
    .fill_i       (buf_fill_c),
    .wr_i         (buf_wr_c),
    .upd_tag_i    (word_q),
    .upd_data_i   (buf_upd_data_c)
  );
`endif

  // Next-state, SRAM pin and read-data sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    word_d    = word_q;
    lo_d      = lo_q;
    mem_out_d = mem_out_q;
    addr_d    = addr_q;
    we_n_d    = we_n_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    ready_c   = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        ready_c = !req_c;
        if (req_c) begin
          wr_d   = MEM_W_EN;
          word_d = req_word_c;
          cnt_d  = '0;
`ifdef SRAM_RD_BUF_EN
          if (!MEM_W_EN && buf_hit_c) begin
            state_d   = ST_DONE;
            mem_out_d = buf_data;
          end else
`endif
          begin
            state_d = ST_LO;
            addr_d  = {req_word_c, 1'b0};
            we_n_d  = !MEM_W_EN;
            oe_d    = MEM_W_EN;
            dout_d  = Val_RM[SRAM_DATA_W-1:0];
          end
        end
      end

      ST_LO: begin
        ready_c = 1'b0;
        if (last_c) begin
          state_d = ST_HI;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          dout_d  = Val_RM[2*SRAM_DATA_W-1:SRAM_DATA_W];
          if (!wr_q) begin
            lo_d = SRAM_DQ;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HI: begin
        ready_c = 1'b0;
        if (last_c) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          oe_d    = 1'b0;
          if (!wr_q) begin
            mem_out_d = WORD_LEN'({SRAM_DQ, lo_q});
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        ready_c = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      word_q    <= '0;
      lo_q      <= '0;
      mem_out_q <= '0;
      addr_q    <= '0;
      we_n_q    <= 1'b1;
      dout_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      word_q    <= word_d;
      lo_q      <= lo_d;
      mem_out_q <= mem_out_d;
      addr_q    <= addr_d;
      we_n_q    <= we_n_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
    end
  end

  // Pin drive; the data bus is released immediately while reset is held
  assign ready      = rst | ready_c;
  assign memory_out = mem_out_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_DQ    = (oe_q && !rst) ? dout_q : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_mem_responder.sv
// Scoreboard bench for sram_mem_responder against a simple async SRAM model.
module tb_sram_mem_responder;

`ifdef SRAM_RD_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int W    = 2;
  localparam int FULL = 2 * W + 1;
  localparam int HITL = BUF ? 1 : FULL;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_RM;
  logic [31:0] memory_out;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  always #5 clk = ~clk;

  sram_mem_responder #(
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (W),
    .SRAM_ADDR_W (18),
    .SRAM_DATA_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_Res    (ALU_Res),
    .Val_RM     (Val_RM),
    .memory_out (memory_out),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  // Async SRAM model; an undriven bus reads as all ones through the pullup
  logic [15:0] sram [0:(1<<18)-1];
  logic        model_en;
  logic        pre_en;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  pullup (SRAM_DQ);
  assign SRAM_DQ = (SRAM_WE_N && model_en) ? sram[SRAM_ADDR] : 16'hzzzz;

  always @(posedge clk) begin
    if (pre_en) sram[pre_addr] <= pre_data;
    else if (!rst && !SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: each ready 0->1 completion pops one expected response
  int lat = 0;
  always @(negedge clk) begin
    if (rst) begin
      lat = 0;
    end else if (!ready) begin
      lat++;
    end else if (lat > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'(lat), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("memory_out", memory_out, e.data);
        check("latency", 32'(lat), 32'(e.lat));
      end
      lat = 0;
    end
  end

  task automatic idle();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    model_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue one request in the current IDLE cycle and follow it to DONE
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_out,
                        input int exp_lat, input logic chk_bus, input logic [17:0] lo_addr);
    exp_t e;
    bit   done = 0;
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    ALU_Res  = addr;
    Val_RM   = data;
    model_en = rd && !wr;
    e.data = exp_out;
    e.lat  = exp_lat;
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (chk_bus && c >= 1 && c <= 2 * W) begin
        check("sram_addr", 32'(SRAM_ADDR), 32'(lo_addr | 18'(c > W)));
        check("sram_we_n", 32'(SRAM_WE_N), 32'(!wr));
        if (wr) check("sram_dq_wr", 32'(SRAM_DQ), (c > W) ? 32'(data[31:16]) : 32'(data[15:0]));
      end
      if (c >= 1 && ready) done = 1;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  logic [17:0] saved_addr;

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
    ALU_Res = 32'd1024; Val_RM = 32'd0;
    model_en = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    #1;
    // Preload words read by the address-mapping vectors while in reset
    pre_en = 1'b1;
    pre_addr = 18'd6;       pre_data = 16'h1111; @(posedge clk); #1;
    pre_addr = 18'd7;       pre_data = 16'h2222; @(posedge clk); #1;
    pre_addr = 18'h3FFFE;   pre_data = 16'hAAAA; @(posedge clk); #1;
    pre_addr = 18'h3FFFF;   pre_data = 16'h5555; @(posedge clk); #1;
    pre_en = 1'b0;
    @(negedge clk);
    check("ready_in_reset", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; MEM_R_EN = 1'b0;
    @(negedge clk);
    check("rst_memory_out", memory_out, 32'd0);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_dq_z", 32'(SRAM_DQ), 32'hFFFF);
    check("rst_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    // Write then read back word 0
    do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0, FULL, 1'b1, 18'd0);
    idle();
    do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'hDEADBEEF, FULL, 1'b1, 18'd0);
    MEM_R_EN = 1'b0; model_en = 1'b0;
    @(negedge clk);
    check("idle_dq_z", 32'(SRAM_DQ), 32'hFFFF);
    check("idle_we_n", 32'(SRAM_WE_N), 32'd1);
    @(posedge clk); #1;

    // Address mapping, byte-lane bits ignored, wrap below the base
    do_req(1'b1, 1'b0, 32'd1036, 32'd0, 32'h22221111, FULL, 1'b1, 18'd6);
    idle();
    do_req(1'b1, 1'b0, 32'd1039, 32'd0, 32'h22221111, HITL, !BUF, 18'd6);
    idle();
    do_req(1'b1, 1'b0, 32'd1020, 32'd0, 32'h5555AAAA, FULL, 1'b1, 18'h3FFFE);
    idle();

    // Reset in cycle 2 of a write aborts it
    MEM_W_EN = 1'b1; ALU_Res = 32'd1100; Val_RM = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_forced_rst", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; MEM_W_EN = 1'b0;
    @(negedge clk);
    check("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    check("abort_dq_z", 32'(SRAM_DQ), 32'hFFFF);
    check("abort_memory_out", memory_out, 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, FULL, 1'b1, 18'd0);
    idle();

    // Back-to-back read then write with both enables set
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, HITL, !BUF, 18'd0);
    do_req(1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, FULL, 1'b1, 18'd2);
    idle();
    do_req(1'b1, 1'b0, 32'd1028, 32'd0, 32'h12345678, FULL, 1'b1, 18'd2);
    idle();

`ifdef SRAM_RD_BUF_EN
    // Miss, then hit with no SRAM activity, then write-through
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, FULL, 1'b1, 18'd0);
    idle();
    saved_addr = SRAM_ADDR;
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, 1, 1'b0, 18'd0);
    check("hit_no_addr", 32'(SRAM_ADDR), 32'(saved_addr));
    check("hit_no_we", 32'(SRAM_WE_N), 32'd1);
    idle();
    do_req(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, FULL, 1'b1, 18'd0);
    idle();
    do_req(1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1, 1'b0, 18'd0);
    idle();
`else
    saved_addr = '0;
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Responder side of the Mem-stage data-memory request interface.
- Accepts the stage's read/write requests (MEM_R_EN, MEM_W_EN, ALU_Res address, Val_RM write data) and services them on an external 16-bit asynchronous SRAM, using two half-word accesses per 32-bit word.
- Drives `ready` low while busy so the pipeline freezes.
- Returns read data on `memory_out`.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles each half-word SRAM access is held (min 1).
- SRAM_ADDR_W, 18: SRAM address width.
- SRAM_DATA_W, 16: SRAM data width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- MEM_R_EN  input  1  read request
- MEM_W_EN  input  1  write request
- ALU_Res  input  `ADDRESS_LEN  byte address
- Val_RM  input  `WORD_LEN  write data
- memory_out  output  `WORD_LEN  read data, registered
- ready  output  1  1 = no stall / request complete
- SRAM_ADDR  output  SRAM_ADDR_W  half-word address
- SRAM_DQ  inout  SRAM_DATA_W  SRAM data bus
- SRAM_WE_N  output  1  active-low write enable

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE, memory_out=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, wait counter=0.
  - ready is forced to 1 while rst=1.
  - Reset mid-access aborts the access; the next cycle is IDLE with no partial update to memory_out.
- Address: word = (ALU_Res − BASE_ADDR) >> 2.
  - Unsigned subtraction, truncated to SRAM_ADDR_W−1 bits, so wrap-around is silent.
  - ALU_Res[1:0] is ignored.
  - SRAM_ADDR = {word, half}, with half=0 for bits[15:0] and half=1 for bits[31:16].
- States: IDLE, LO, HI, DONE.
  - IDLE → LO when (MEM_R_EN | MEM_W_EN). If both are high, the request is treated as a write.
  - LO → HI after WAIT_CYCLES cycles.
  - HI → DONE after WAIT_CYCLES cycles.
  - DONE → IDLE unconditionally. Inputs during DONE are still the completed request and are never restarted.
- ready (combinational):
  - IDLE: ~(MEM_R_EN | MEM_W_EN).
  - LO, HI: 0.
  - DONE: 1.
- Timing: a request seen in IDLE at cycle 0 gives ready=0 for cycles 0..2·WAIT_CYCLES and ready=1 at cycle 2·WAIT_CYCLES+1.
- Requester holds the enables, address and data stable while ready=0.
- Write:
  - SRAM_WE_N=0 for all cycles in LO/HI.
  - SRAM_DQ drives Val_RM[15:0] in LO and Val_RM[31:16] in HI.
  - memory_out is unchanged.
- Read:
  - SRAM_WE_N=1, SRAM_DQ=Z.
  - The low half is latched on the last LO cycle, the high half on the last HI cycle.
  - memory_out updates on the HI→DONE edge and holds until the next read completes.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE, leaving a minimum 1-cycle gap.
- SRAM_DQ is driven only in write LO/HI; it is Z in every other state and under reset.

Optional Feature:
- Macro: SRAM_RD_BUF_EN
- Defined: adds a single-entry last-word buffer (tag, data, valid).
  - Read hit in IDLE goes directly to DONE: ready=0 at cycle 0, ready=1 at cycle 1, memory_out=buffer data, no SRAM activity.
  - Read miss fills the buffer at DONE.
  - A write to the tagged word updates the buffer data at DONE (write-through).
  - rst clears valid.
- Undefined: no buffer. Every read takes the full SRAM sequence.

Decomposition:
- Shared package/header (alongside configs.v) holds:
  - SRAM_ADDR_W and SRAM_DATA_W defaults.
  - State encoding constants (IDLE/LO/HI/DONE).
  - The BASE_ADDR default.
  - WORD_LEN/ADDRESS_LEN, reused from configs.v.
- One natural sub-module: sram_read_buffer, containing the tag/data/valid registers, hit compare and update port. It is instantiated only under SRAM_RD_BUF_EN.

Test Plan (all with WAIT_CYCLES=2, BASE_ADDR=1024):
1. Write: ALU_Res=1024, Val_RM=0xDEADBEEF at cycle 0 → SRAM_ADDR=0, DQ=0xBEEF, WE_N=0 in cycles 1–2; SRAM_ADDR=1, DQ=0xDEAD in cycles 3–4; ready=1 at cycle 5; memory_out unchanged.
2. Read of 1024 against an SRAM model → ready=0 in cycles 0–4; memory_out=0xDEADBEEF and ready=1 at cycle 5; DQ is Z throughout.
3. Address mapping: ALU_Res=1036 and ALU_Res=1039 → SRAM_ADDR 6 then 7. ALU_Res=1020 → word wraps to all-ones, SRAM_ADDR=0x3FFFE/0x3FFFF.
4. rst=1 in cycle 2 of a write → next cycle IDLE, WE_N=1, DQ=Z, memory_out=0; a new read then completes in 6 cycles.
5. Read(1024) followed immediately by write(1028, 0x12345678) → write LO begins in the cycle after the IDLE following read DONE. Both MEM_R_EN=MEM_W_EN=1 → write performed.
6. With SRAM_RD_BUF_EN:
   - Repeat read 1024 → ready=1 at cycle 1, no SRAM_ADDR/WE_N activity.
   - Write 1024=0x12345678, then read 1024 → hit returns 0x12345678.
